tacky_issue: RTL

TACKY_ISSUE -- requirements
Module: tacky_issue

---
 rtl/tacky_issue_if.sv | 27 ++
 rtl/tacky_issue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/tacky_issue_if.sv
// Fetch, issue-slot and redirect signals between tacky_issue and its neighbours.
// master = issue unit side, slave = memory / execute / PC-stage side.
interface tacky_issue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_op;
  logic [2:0]  iss_reg;
  logic        iss_slot;
  logic [15:0] iss_imm;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, iss_valid, iss_op, iss_reg, iss_slot, iss_imm, halted,
    input  imem_ready, imem_data, iss_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, iss_valid, iss_op, iss_reg, iss_slot, iss_imm, halted,
    output imem_ready, imem_data, iss_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/tacky_issue.sv
// Two-slot instruction issue unit: fetches 16-bit words and issues one 8-bit slot per cycle.
// Define TACKY_PRE_EN to enable the OPpre prefix register that supplies iss_imm[15:8].
//
// state | meaning
// FETCH | requesting word at pc from instruction memory
// SLOT1 | presenting ir[15:8] (or whole-word imm8 form)
// SLOT2 | presenting ir[7:0]
// HALT  | OPsys issued; idle until reset
module tacky_issue (
  input  logic          clk,
  input  logic          reset,
  tacky_issue_if.master bus
);
  typedef enum logic [1:0] {FETCH, SLOT1, SLOT2, HALT} state_t;

  localparam logic [4:0] OP_SYS = 5'b11111;

  state_t      state, state_nxt;
  logic [15:0] pc, ir, imm_ext;
  logic        run, halted_q;
  logic [4:0]  op1, op2;
  logic        imm_form, pre_op, consume, fetch_done;

  assign op1        = ir[15:11];
  assign op2        = ir[7:3];
  assign imm_form   = (op1[4:3] == 2'b11);
  assign consume    = bus.iss_valid && bus.iss_ready;
  assign fetch_done = bus.imem_req && bus.imem_ready;

`ifdef TACKY_PRE_EN
  localparam logic [4:0] OP_PRE = 5'b11110;
  logic [7:0] pre;

  assign pre_op  = (op1 == OP_PRE);
  assign imm_ext = {pre, ir[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pre <= 8'h00;
    else if (state == SLOT1 && pre_op && !bus.redirect)
      pre <= ir[7:0];
  end
`else
  assign pre_op  = 1'b0;
  assign imm_ext = {{8{ir[7]}}, ir[7:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  // An issued OPsys halts even if a redirect arrives in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (fetch_done && !bus.redirect) state_nxt = SLOT1;
      SLOT1, SLOT2: begin
        if (consume && bus.iss_op == OP_SYS)
          state_nxt = HALT;
        else if (bus.redirect || pre_op)
          state_nxt = FETCH;
        else if (consume)
          state_nxt = (state == SLOT1 && !imm_form) ? SLOT2 : FETCH;
      end
      HALT:  state_nxt = HALT;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_op    = 5'd0;
    bus.iss_reg   = 3'd0;
    bus.iss_slot  = 1'b0;
    bus.iss_imm   = 16'h0000;
    unique case (state)
      FETCH: bus.imem_req = run;
      SLOT1: begin
        bus.iss_valid = !pre_op;
        bus.iss_op    = op1;
        bus.iss_reg   = ir[10:8];
        if (imm_form) bus.iss_imm = imm_ext;
      end
      SLOT2: begin
        bus.iss_valid = 1'b1;
        bus.iss_op    = op2;
        bus.iss_reg   = ir[2:0];
        bus.iss_slot  = 1'b1;
      end
      HALT: ;
    endcase
  end

  assign bus.imem_addr = pc;
  assign bus.halted    = halted_q;

  // run holds off imem_req until the first clock after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= 16'h0000;
      ir       <= 16'h0000;
      run      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (state_nxt == HALT) halted_q <= 1'b1;
      if (state == FETCH) begin
        if (bus.redirect)
          pc <= bus.redirect_pc;
        else if (fetch_done)
          ir <= bus.imem_data;
      end else if (state != HALT && state_nxt == FETCH) begin
        pc <= bus.redirect ? bus.redirect_pc : pc + 16'd1;
      end
    end
  end
endmodule
